// File: rtl/instr_sequencer_pkg.sv
// Shared constants, opcode encodings and FSM state type for the instruction sequencer.
// Instruction word layout: {opcode[2:0], reg_x[1:0], reg_y[1:0], imm[3:0]}.
package instr_sequencer_pkg;

   localparam int INSTR_W    = 11;
   localparam int ADDR_W     = 4;
   localparam int DEPTH      = 16;
   localparam int LEN_W      = 5;
   localparam int OPC_W      = 3;
   localparam int HOLD_W     = 3;

   localparam int HOLD_LOAD  = 3;
   localparam int HOLD_ALU   = 5;
   localparam int GAP_CYCLES = 1;

   localparam logic [OPC_W-1:0] OP_LOAD = 3'b000;
   localparam logic [OPC_W-1:0] OP_MOV  = 3'b001;
   localparam logic [OPC_W-1:0] OP_SUB  = 3'b010;
   localparam logic [OPC_W-1:0] OP_ADD  = 3'b011;
   localparam logic [OPC_W-1:0] OP_DISP = 3'b100;
   localparam logic [OPC_W-1:0] OP_SUBI = 3'b110;
   localparam logic [OPC_W-1:0] OP_ADDI = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } state_e;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1 -: OPC_W];
   endfunction

   // Counter reload value: the counter runs down to zero, so it holds length-1.
   function automatic logic [HOLD_W-1:0] hold_reload(input logic [OPC_W-1:0] op);
      if (op == OP_LOAD)
         return HOLD_W'(HOLD_LOAD - 1);
      return HOLD_W'(HOLD_ALU - 1);
   endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// 16 x 11 program store: one synchronous write port, one asynchronous read port.
// Deliberately has no reset so a program survives a reset of the sequencer.
module seq_prog_mem
   import instr_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through a stored program, presenting each word on instr with an exec strobe
// held for an opcode-dependent number of cycles, separated by a one-cycle gap.
module instr_sequencer
   import instr_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [LEN_W-1:0]   prog_len,
   input  logic               start,
   input  logic               abort,
   output logic               exec,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_d;
   logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_d;
   logic               exec_d, busy_d, done_d;
   logic               load_instr;

   logic               mem_we;
   logic [ADDR_W-1:0]  rd_addr;
   logic [INSTR_W-1:0] rd_word;
   logic [INSTR_W-1:0] fetch_word;
   logic [LEN_W-1:0]   len_clip;

   assign mem_we   = prog_we && (state_q == IDLE);
   assign len_clip = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
   assign rd_addr  = (state_q == GAP) ? pc + 1'b1 : '0;

   // A write landing on the start edge is forwarded so the run sees the new word.
   assign fetch_word = (mem_we && (prog_addr == rd_addr)) ? prog_data : rd_word;

   seq_prog_mem u_prog_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .rd_addr (rd_addr),
      .rd_data (rd_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc        <= '0;
         last_pc_q <= '0;
         cnt_q     <= '0;
         instr     <= '0;
         exec      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc        <= pc_d;
         last_pc_q <= last_pc_d;
         cnt_q     <= cnt_d;
         instr     <= instr_d;
         exec      <= exec_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc;
      last_pc_d  = last_pc_q;
      cnt_d      = cnt_q;
      load_instr = 1'b0;
      instr_d    = '0;
      exec_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (len_clip == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d    = ISSUE;
                  pc_d       = '0;
                  last_pc_d  = ADDR_W'(len_clip - 1'b1);
                  cnt_d      = hold_reload(opcode_of(fetch_word));
                  load_instr = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               state_d = FINISH;
            end else if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = HOLD_W'(GAP_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (abort) begin
               state_d = FINISH;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (pc == last_pc_q) begin
               state_d = FINISH;
            end else begin
               state_d    = ISSUE;
               pc_d       = pc + 1'b1;
               cnt_d      = hold_reload(opcode_of(fetch_word));
               load_instr = 1'b1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      exec_d = (state_d == ISSUE);
      busy_d = (state_d == ISSUE) || (state_d == GAP);
      done_d = (state_d == FINISH);
      if (load_instr)
         instr_d = fetch_word;
      else if (state_d == ISSUE)
         instr_d = instr;
   end

endmodule
